// File: rtl/product_display.sv
// Captures an 8-bit product, converts it to 3-digit BCD with a bit-serial double-dabble
// engine, and drives a multiplexed common-anode 7-segment display with leading-zero blanking.
module product_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  p_in,
    input  logic        p_valid,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t         state, next_state;
    logic [7:0]     bin;
    logic [11:0]    scratch;
    logic [11:0]    adj;
    logic [2:0]     count;
    logic [CW-1:0]  refresh_cnt;
    logic [1:0]     digit_idx;
    logic [1:0]     next_idx;
    logic [2:0]     next_an;
    logic [3:0]     digit;
    logic           blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (p_valid) next_state = CONV;
            CONV:    if (count == 3'd7) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin     <= '0;
            scratch <= '0;
            count   <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (p_valid) begin
                        bin     <= p_in;
                        scratch <= '0;
                        count   <= '0;
                    end
                end
                CONV: begin
                    scratch <= {adj[10:0], bin[7]};
                    bin     <= {bin[6:0], 1'b0};
                    count   <= count + 3'd1;
                end
                DONE: begin
                    bcd  <= scratch;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_idx = (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        case (next_idx)
            2'd0:    next_an = 3'b110;
            2'd1:    next_an = 3'b101;
            default: next_an = 3'b011;
        endcase
    end

    // an is registered alongside the digit index so the two never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            an          <= 3'b110;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= next_idx;
            an          <= next_an;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    always_comb begin
        case (digit_idx)
            2'd0:    begin digit = bcd[3:0];  blank = 1'b0; end
            2'd1:    begin digit = bcd[7:4];  blank = (bcd[11:4] == 8'h00); end
            default: begin digit = bcd[11:8]; blank = (bcd[11:8] == 4'h0); end
        endcase
    end

    always_comb begin
        seg = 7'b1111111;
        if (!blank) begin
            case (digit)
                4'd0: seg = 7'b1000000;
                4'd1: seg = 7'b1111001;
                4'd2: seg = 7'b0100100;
                4'd3: seg = 7'b0110000;
                4'd4: seg = 7'b0011001;
                4'd5: seg = 7'b0010010;
                4'd6: seg = 7'b0000010;
                4'd7: seg = 7'b1111000;
                4'd8: seg = 7'b0000000;
                4'd9: seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

endmodule
